// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Purpose: FSM sequencer for the 4-bit multicycle CPU datapath. It decodes the
// opcode held in the instruction register and drives every datapath strobe and
// mux select, one instruction at a time.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset (0 = reset)
//   run        in   start request, sampled only in IDLE
//   opcode     in   opcode field of the instruction register (opcode_t)
//   zero       in   registered ALU zero flag
//   ir_write   out  load instruction register
//   pc_write   out  load program counter
//   reg_write  out  write register file (rd)
//   mem_write  out  write data memory
//   alu_write  out  load ALU result register
//   zero_write out  load zero-flag register
//   alu_sel1   out  operand-1 select: 0=rd, 1=imm4, 2=const 1, 3=0
//   alu_sel2   out  operand-2 select: 0=imm2, 1=pc, 2=rs, 3=0
//   alu_op     out  ALU operation (alu_operation_t)
//   result_sel out  result select: 0=mem read data, 1=alu_out, 2=alu_result
//   halted     out  core stopped (HALT or illegal opcode)
//   illegal    out  stop was caused by an undefined opcode
//   retired    out  retired-instruction count [CNT_WIDTH-1:0]
//                   (only when CTRL_RETIRE_CNT_EN is defined)
//
// Optional feature macro: CTRL_RETIRE_CNT_EN
// -----------------------------------------------------------------------------

package multicycle_control_unit_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_ADDI = 4'd5,
        OP_LD   = 4'd6,
        OP_ST   = 4'd7,
        OP_BEQZ = 4'd8,
        OP_JMP  = 4'd9,
        OP_HALT = 4'd15
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_operation_t;

endpackage

module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    input  opcode_t        opcode,
    input  logic           zero,
    output logic           ir_write,
    output logic           pc_write,
    output logic           reg_write,
    output logic           mem_write,
    output logic           alu_write,
    output logic           zero_write,
    output logic [1:0]     alu_sel1,
    output logic [1:0]     alu_sel2,
    output alu_operation_t alu_op,
    output logic [1:0]     result_sel,
    output logic           halted,
    output logic           illegal
`ifdef CTRL_RETIRE_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] retired
`endif
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_WB     = 4'd4,
        S_MEM_RD = 4'd5,
        S_LD_WB  = 4'd6,
        S_MEM_WR = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_STOP   = 4'd10
    } state_t;

    typedef struct packed {
        logic           ir_write;
        logic           pc_write;
        logic           reg_write;
        logic           mem_write;
        logic           alu_write;
        logic           zero_write;
        logic [1:0]     alu_sel1;
        logic [1:0]     alu_sel2;
        alu_operation_t alu_op;
        logic [1:0]     result_sel;
    } ctrl_t;

    if (CNT_WIDTH < 1) begin : g_cnt_width_invalid
        $error("CNT_WIDTH must be at least 1");
    end

    state_t state_r;
    state_t state_nxt_s;
    logic   illegal_hit_s;
    ctrl_t  ctrl_r;
    logic   halted_r;
    logic   illegal_r;

    // Control word for a given state. EXEC needs the opcode to pick the ALU
    // operation; it is sampled on the DECODE->EXEC edge while IR is stable.
    // The BRANCH pc_write term is left out here: it follows zero live.
    function automatic ctrl_t decode_ctrl(input state_t st, input opcode_t op);
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_ADD;
        case (st)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_write   = 1'b1;
                c.alu_sel1   = 2'd2;
                c.alu_sel2   = 2'd1;
                c.result_sel = 2'd2;
            end
            S_EXEC: begin
                c.alu_write  = 1'b1;
                c.zero_write = 1'b1;
                c.alu_sel1   = 2'd0;
                case (op)
                    OP_SUB:  begin c.alu_sel2 = 2'd2; c.alu_op = ALU_SUB; end
                    OP_AND:  begin c.alu_sel2 = 2'd2; c.alu_op = ALU_AND; end
                    OP_OR:   begin c.alu_sel2 = 2'd2; c.alu_op = ALU_OR;  end
                    OP_ADDI: begin c.alu_sel2 = 2'd0; c.alu_op = ALU_ADD; end
                    default: begin c.alu_sel2 = 2'd2; c.alu_op = ALU_ADD; end
                endcase
            end
            S_WB: begin
                c.reg_write  = 1'b1;
                c.result_sel = 2'd1;
            end
            S_LD_WB: begin
                c.reg_write  = 1'b1;
                c.result_sel = 2'd0;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_sel1   = 2'd1;
                c.alu_sel2   = 2'd1;
                c.result_sel = 2'd2;
            end
            S_JUMP: begin
                c.pc_write   = 1'b1;
                c.alu_sel1   = 2'd1;
                c.alu_sel2   = 2'd3;
                c.result_sel = 2'd2;
            end
            default: begin
                c.ir_write = 1'b0;
            end
        endcase
        return c;
    endfunction

    // Next-state decode; unreachable encodings fall back to IDLE.
    always_comb begin
        state_nxt_s   = S_IDLE;
        illegal_hit_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (run) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_FETCH:  state_nxt_s = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_NOP:  state_nxt_s = S_FETCH;
                    OP_ADD,
                    OP_SUB,
                    OP_AND,
                    OP_OR,
                    OP_ADDI: state_nxt_s = S_EXEC;
                    OP_LD:   state_nxt_s = S_MEM_RD;
                    OP_ST:   state_nxt_s = S_MEM_WR;
                    OP_BEQZ: state_nxt_s = S_BRANCH;
                    OP_JMP:  state_nxt_s = S_JUMP;
                    OP_HALT: state_nxt_s = S_STOP;
                    default: begin
                        state_nxt_s   = S_STOP;
                        illegal_hit_s = 1'b1;
                    end
                endcase
            end
            S_EXEC:   state_nxt_s = S_WB;
            S_WB:     state_nxt_s = S_FETCH;
            S_MEM_RD: state_nxt_s = S_LD_WB;
            S_LD_WB:  state_nxt_s = S_FETCH;
            S_MEM_WR: state_nxt_s = S_FETCH;
            S_BRANCH: state_nxt_s = S_FETCH;
            S_JUMP:   state_nxt_s = S_FETCH;
            S_STOP:   state_nxt_s = S_STOP;
            default:  state_nxt_s = S_IDLE;
        endcase
    end

    // State register plus registered outputs, decoded from the next state so
    // that strobes line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= S_IDLE;
            ctrl_r    <= '0;
            halted_r  <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ctrl_r    <= decode_ctrl(state_nxt_s, opcode);
            halted_r  <= (state_nxt_s == S_STOP);
            illegal_r <= illegal_r | illegal_hit_s;
        end
    end

`ifdef CTRL_RETIRE_CNT_EN
    logic [CNT_WIDTH-1:0] retired_r;

    // Retire count: every return to FETCH except the initial IDLE start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            retired_r <= '0;
        end else if ((state_nxt_s == S_FETCH) && (state_r != S_IDLE)) begin
            retired_r <= retired_r + CNT_WIDTH'(1);
        end else begin
            retired_r <= retired_r;
        end
    end

    assign retired = retired_r;
`endif

    assign ir_write   = ctrl_r.ir_write;
    // Branch taken follows the live zero flag while in BRANCH.
    assign pc_write   = ctrl_r.pc_write | ((state_r == S_BRANCH) & zero);
    assign reg_write  = ctrl_r.reg_write;
    assign mem_write  = ctrl_r.mem_write;
    assign alu_write  = ctrl_r.alu_write;
    assign zero_write = ctrl_r.zero_write;
    assign alu_sel1   = ctrl_r.alu_sel1;
    assign alu_sel2   = ctrl_r.alu_sel2;
    assign alu_op     = ctrl_r.alu_op;
    assign result_sel = ctrl_r.result_sel;
    assign halted     = halted_r;
    assign illegal    = illegal_r;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- FSM sequencer for the 4-bit multicycle CPU datapath.
- Drives every datapath strobe and mux select: IR/PC/register/memory/ALU/zero-flag writes, ALU operand selects, ALU operation and result select.
- Decodes the 4-bit opcode from the instruction register and the registered zero flag.
- Sits beside data_path inside the CPU top; one instruction in flight at a time.

Parameters:
CNT_WIDTH, 16, width of the retired-instruction counter. Used only when the optional feature is compiled in.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
run  input  1  start request; sampled in IDLE
opcode  input  4 (opcode_t)  opcode field of the instruction register
zero  input  1  registered ALU zero flag
ir_write  output  1  load instruction register
pc_write  output  1  load program counter
reg_write  output  1  write register file (rd)
mem_write  output  1  write data memory
alu_write  output  1  load ALU result register
zero_write  output  1  load zero-flag register
alu_sel1  output  2  operand-1 select: 0=rd2 (rd), 1=imm4, 2=const 1, 3=0
alu_sel2  output  2  operand-2 select: 0=zero-extended imm2, 1=pc, 2=rd1 (rs), 3=0
alu_op  output  alu_operation_t  ALU_ADD / ALU_SUB / ALU_AND / ALU_OR
result_sel  output  2  result select: 0=memory read data, 1=alu_out, 2=alu_result
halted  output  1  core stopped (HALT or illegal opcode)
illegal  output  1  stop was caused by an undefined opcode

Behaviour:
- Moore FSM; all outputs decode from the state register only, except pc_write in BRANCH (depends on zero).
- Opcode encoding: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 ADDI, 6 LD, 7 ST, 8 BEQZ, 9 JMP, 15 HALT. Values 10–14 are illegal.
- Default outputs in every state: all strobes 0, selects 0, alu_op=ALU_ADD. Each state below lists only deviations.
- reset=0 at a clock edge: state<=IDLE, halted<=0, illegal<=0. Reset overrides everything, mid-instruction or while halted. Strobes are 0 during the reset cycle.
- IDLE: no strobes. Goes to FETCH when run=1.
- FETCH: ir_write=1, pc_write=1, alu_sel1=2, alu_sel2=1, result_sel=2. Loads IR with mem[pc] and sets pc<=pc+1. Next state DECODE.
- DECODE: no strobes; opcode is now valid. Next state:
  - NOP → FETCH
  - ADD/SUB/AND/OR/ADDI → EXEC
  - LD → MEM_RD
  - ST → MEM_WR
  - BEQZ → BRANCH
  - JMP → JUMP
  - HALT → STOP
  - illegal → STOP, with illegal<=1.
- EXEC: alu_write=1, zero_write=1, alu_sel1=0.
  - R-type: alu_sel2=2; alu_op = ADD/SUB/AND/OR. SUB computes rd−rs.
  - ADDI: alu_sel2=0, alu_op=ALU_ADD.
  - Next state WB.
- WB: reg_write=1, result_sel=1. Next state FETCH.
- MEM_RD: no strobes; address rs is presented. Next state LD_WB.
- LD_WB: reg_write=1, result_sel=0. Next state FETCH.
- MEM_WR: mem_write=1; writes mem[rs] <= rd. Next state FETCH.
- BRANCH: alu_sel1=1, alu_sel2=1, result_sel=2, pc_write=zero. Target is pc(already incremented)+imm4, mod 16. Next state FETCH.
- JUMP: alu_sel1=1, alu_sel2=3, result_sel=2, pc_write=1. Sets pc<=imm4. Next state FETCH.
- STOP: halted=1; stays here until reset. run is ignored.
- Cycle counts per instruction:
  - NOP: 2
  - R-type/ADDI: 4
  - LD: 4
  - ST: 3
  - BEQZ: 3
  - JMP: 3
  - HALT/illegal: 2, then parked.
- PC arithmetic wraps mod 16: fetch at pc=15 yields next pc=0.
- zero is updated only by EXEC. BEQZ tests the flag from the most recent ALU instruction. Reset value of the flag is owned by the datapath.
- Unreachable state encodings recover to IDLE on the next clock.

Optional Feature:
- Macro: CTRL_RETIRE_CNT_EN.
- Defined:
  - Adds output retired [CNT_WIDTH-1:0]. Reset to 0.
  - Increments by 1 on each transition back into FETCH from DECODE, WB, LD_WB, MEM_WR, BRANCH or JUMP.
  - Does not count HALT or illegal. Wraps at 2^CNT_WIDTH.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset/start: hold reset=0 for 2 cycles, then reset=1 with run=0 for 5 cycles → all strobes 0, halted=0. Assert run=1 → next cycle ir_write=1, pc_write=1, alu_sel1=2, alu_sel2=1, result_sel=2.
- ADD (opcode 1): FETCH, DECODE, EXEC (alu_sel2=2, alu_op=ALU_ADD, alu_write=1, zero_write=1), WB (reg_write=1, result_sel=1), back in FETCH on cycle 5. Repeat for SUB/AND/OR with alu_op checked.
- LD (6) then ST (7): LD gives reg_write=1 with result_sel=0 in its 4th cycle. ST gives mem_write=1 for exactly 1 cycle in its 3rd cycle and reg_write stays 0.
- BEQZ (8):
  - zero=1 → pc_write=1 in BRANCH with alu_sel1=1, alu_sel2=1.
  - zero=0 → pc_write=0.
  - JMP (9) → pc_write=1 with alu_sel2=3.
- Stop paths:
  - Opcode 15 → halted=1, illegal=0. Stays halted 10 cycles with run=1 and no strobes.
  - Opcode 12 → halted=1, illegal=1.
  - reset=0 during EXEC of an ADD → IDLE next cycle, no WB strobe issued.
- With CTRL_RETIRE_CNT_EN: run NOP, ADD, ST, HALT → retired=3. After reset, retired=0.
